// File: rtl/gf_pkg.sv
`default_nettype none
// ============================================================================
// gf_pkg
// Shared types and constants for the sequential GF(2^m) inverter.
// Revision: 1.0 - initial release
// ============================================================================
package gf_pkg;

  // FSM state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } gf_state_t;

  // Irreducible reduction polynomials, one per field degree 2..16
  localparam int unsigned GF_POLY_DEG2  = 7;
  localparam int unsigned GF_POLY_DEG3  = 11;
  localparam int unsigned GF_POLY_DEG4  = 19;
  localparam int unsigned GF_POLY_DEG5  = 37;
  localparam int unsigned GF_POLY_DEG6  = 67;
  localparam int unsigned GF_POLY_DEG7  = 137;
  localparam int unsigned GF_POLY_DEG8  = 285;
  localparam int unsigned GF_POLY_DEG9  = 529;
  localparam int unsigned GF_POLY_DEG10 = 1033;
  localparam int unsigned GF_POLY_DEG11 = 2053;
  localparam int unsigned GF_POLY_DEG12 = 4179;
  localparam int unsigned GF_POLY_DEG13 = 8219;
  localparam int unsigned GF_POLY_DEG14 = 17475;
  localparam int unsigned GF_POLY_DEG15 = 32771;
  localparam int unsigned GF_POLY_DEG16 = 69643;

  // Width of the field-degree input able to hold the value DATA_WIDTH
  function automatic int gf_width(input int data_width);
    return $clog2(data_width) + 1;
  endfunction

  // Table lookup of the irreducible polynomial for a degree (0 if none)
  function automatic int unsigned gf_poly(input int deg);
    case (deg)
      2:       return GF_POLY_DEG2;
      3:       return GF_POLY_DEG3;
      4:       return GF_POLY_DEG4;
      5:       return GF_POLY_DEG5;
      6:       return GF_POLY_DEG6;
      7:       return GF_POLY_DEG7;
      8:       return GF_POLY_DEG8;
      9:       return GF_POLY_DEG9;
      10:      return GF_POLY_DEG10;
      11:      return GF_POLY_DEG11;
      12:      return GF_POLY_DEG12;
      13:      return GF_POLY_DEG13;
      14:      return GF_POLY_DEG14;
      15:      return GF_POLY_DEG15;
      16:      return GF_POLY_DEG16;
      default: return 0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/gf_half_step.sv
`default_nettype none
// ============================================================================
// gf_half_step
// Combinational division by x modulo f: g even -> g>>1, g odd -> (g^f)>>1.
// Only f[DATA_WIDTH:1] is needed because the low bit of g^f is always
// discarded by the shift.
// Revision: 1.0 - initial release
// ============================================================================
module gf_half_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] g,
  input  logic [DATA_WIDTH-1:0] f_hi,
  output logic [DATA_WIDTH-1:0] h
);

  // Shift g down and fold in f when g is odd, making g^f divisible by x
  always_comb begin
    h = {1'b0, g[DATA_WIDTH-1:1]} ^ (g[0] ? f_hi : '0);
  end

endmodule
`default_nettype wire

// File: rtl/gf_inv_seq.sv
`default_nettype none
// ============================================================================
// gf_inv_seq
// Sequential GF(2^m) inverter using the binary extended Euclidean algorithm,
// one reduction step per clock. Invariants: u = g1*a, v = g2*a (mod f).
// Revision: 1.0 - initial release
// ============================================================================
module gf_inv_seq
  import gf_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [gf_width(DATA_WIDTH)-1:0]   polyn_grade,
  input  logic [DATA_WIDTH:0]               polyn_red_in,
  input  logic [DATA_WIDTH-1:0]             a,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic [DATA_WIDTH-1:0]             inv_out
);

  localparam int                GW     = gf_width(DATA_WIDTH);
  localparam logic [GW-1:0]     M_MIN  = GW'(2);
  localparam logic [GW-1:0]     M_MAX  = GW'(DATA_WIDTH);
  localparam logic [DATA_WIDTH:0] W_ONE  = (DATA_WIDTH+1)'(1);
  localparam logic [DATA_WIDTH:0] W_ZERO = '0;

  gf_state_t               state;
  gf_state_t               state_nxt;
  logic [DATA_WIDTH:0]     u;
  logic [DATA_WIDTH:0]     v;
  logic [DATA_WIDTH-1:0]   g1;
  logic [DATA_WIDTH-1:0]   g2;
  logic [DATA_WIDTH-1:0]   f_hi;
  logic [DATA_WIDTH-1:0]   g1_half;
  logic [DATA_WIDTH-1:0]   g2_half;
  logic                    req_bad;
  logic                    finish;

  gf_half_step #(.DATA_WIDTH(DATA_WIDTH)) u_half_g1 (
    .g    (g1),
    .f_hi (f_hi),
    .h    (g1_half)
  );

  gf_half_step #(.DATA_WIDTH(DATA_WIDTH)) u_half_g2 (
    .g    (g2),
    .f_hi (f_hi),
    .h    (g2_half)
  );

  // Request screening and terminal-condition detection
  always_comb begin
    req_bad = (a == '0)
           || ((a >> polyn_grade) != '0)
           || (polyn_grade < M_MIN)
           || (polyn_grade > M_MAX)
           || !polyn_red_in[0];
    finish  = (u == W_ONE) || (v == W_ONE) || (u == W_ZERO) || (v == W_ZERO);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = req_bad ? ST_DONE : ST_RUN;
      ST_RUN:  if (finish) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the registered state
  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  // Euclidean datapath and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      u       <= '0;
      v       <= '0;
      g1      <= '0;
      g2      <= '0;
      f_hi    <= '0;
      err     <= 1'b0;
      inv_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            inv_out <= '0;
            if (req_bad) begin
              err <= 1'b1;
            end else begin
              err  <= 1'b0;
              u    <= {1'b0, a};
              v    <= polyn_red_in;
              g1   <= DATA_WIDTH'(1);
              g2   <= '0;
              f_hi <= polyn_red_in[DATA_WIDTH:1];
            end
          end
        end
        ST_RUN: begin
          if (u == W_ONE) begin
            inv_out <= g1;
            err     <= 1'b0;
          end else if (v == W_ONE) begin
            inv_out <= g2;
            err     <= 1'b0;
          end else if ((u == W_ZERO) || (v == W_ZERO)) begin
            // a and f share a factor: no inverse exists
            inv_out <= '0;
            err     <= 1'b1;
          end else if (!u[0]) begin
            u  <= u >> 1;
            g1 <= g1_half;
          end else if (!v[0]) begin
            v  <= v >> 1;
            g2 <= g2_half;
          end else if (u > v) begin
            u  <= u ^ v;
            g1 <= g1 ^ g2;
          end else begin
            v  <= v ^ u;
            g2 <= g2 ^ g1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gf_inv_seq.sv
`default_nettype none
// ============================================================================
// tb_gf_inv_seq
// Self-checking bench for gf_inv_seq: directed corner cases plus a random
// sweep of degrees 2..16 checked against a Fermat-power reference
// (a^-1 = a^(2^m-2)) and a multiply/reduce round trip.
// Revision: 1.0 - initial release
// ============================================================================
module tb_gf_inv_seq;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [5:0]    polyn_grade;
  logic [DW:0]   polyn_red_in;
  logic [DW-1:0] a;
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] inv_out;

  int checks = 0;
  int errors = 0;

  int unsigned poly_tab [15] = '{7, 11, 19, 37, 67, 137, 285, 529, 1033,
                                 2053, 4179, 8219, 17475, 32771, 69643};

  always #5 clk = ~clk;

  gf_inv_seq #(.DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .polyn_grade  (polyn_grade),
    .polyn_red_in (polyn_red_in),
    .a            (a),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .inv_out      (inv_out)
  );

  // Single comparison point for the whole bench
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Carry-less product of x and y reduced modulo f of degree m
  function automatic logic [63:0] clmul_red(input logic [63:0] x, input logic [63:0] y,
                                            input logic [63:0] f, input int m);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 32; i++)
      if (y[i]) p = p ^ (x << i);
    for (int i = 63; i >= m; i--)
      if (p[i]) p = p ^ (f << (i - m));
    return p;
  endfunction

  // Field inverse via a^(2^m - 2) by square-and-multiply
  function automatic logic [63:0] ref_inv(input logic [63:0] x, input logic [63:0] f, input int m);
    logic [63:0] r;
    logic [63:0] b;
    logic [63:0] e;
    r = 64'd1;
    b = x;
    e = (64'd1 << m) - 64'd2;
    while (e != 0) begin
      if (e[0]) r = clmul_red(r, b, f, m);
      b = clmul_red(b, b, f, m);
      e = e >> 1;
    end
    return r;
  endfunction

  // One request: latency counted in edges from the accepting edge to done
  task automatic do_op(input int m, input logic [DW:0] f, input logic [DW-1:0] av,
                       input bit hold, output int lat, output logic e,
                       output logic [DW-1:0] inv);
    logic busy_bad;
    busy_bad     = 1'b0;
    polyn_grade  = 6'(m);
    polyn_red_in = f;
    a            = av;
    start        = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      if (!busy) busy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check_val("timeout", {63'b0, done}, 64'd1);
    check_val("busy_seq", {62'b0, busy_bad, busy}, 64'd0);
    e   = err;
    inv = inv_out;
    @(posedge clk); #1;
    check_val("done_pulse", {63'b0, done}, 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int            lat;
    logic          e;
    logic [DW-1:0] inv;
    logic [63:0]   exp_inv;
    logic          saw_done;
    int            m;
    logic [DW:0]   f;
    logic [DW-1:0] av;

    rst = 1'b1; start = 1'b0; polyn_grade = '0; polyn_red_in = '0; a = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", {63'b0, busy}, 64'd0);
    check_val("rst_done", {63'b0, done}, 64'd0);
    check_val("rst_err",  {63'b0, err},  64'd0);
    check_val("rst_inv",  {32'b0, inv_out}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // x^-1 in GF(16), f = x^4+x+1
    do_op(4, 33'd19, 32'd2, 1'b0, lat, e, inv);
    check_val("m4_a2_err", {63'b0, e}, 64'd0);
    check_val("m4_a2_inv", {32'b0, inv}, 64'd9);
    check_val("m4_a2_lat", 64'(lat <= 18), 64'd1);

    // a == 1 finishes on the first RUN cycle
    do_op(4, 33'd19, 32'd1, 1'b0, lat, e, inv);
    check_val("m4_a1_lat", 64'(lat), 64'd2);
    check_val("m4_a1_inv", {32'b0, inv}, 64'd1);
    check_val("m4_a1_err", {63'b0, e}, 64'd0);

    do_op(8, 33'd285, 32'd2, 1'b0, lat, e, inv);
    check_val("m8_a2_inv", {32'b0, inv}, 64'd142);
    check_val("m8_a2_err", {63'b0, e}, 64'd0);

    // Rejected requests: zero operand, operand too wide, bad degree, even f
    do_op(4, 33'd19, 32'd0, 1'b0, lat, e, inv);
    check_val("rej_a0_lat", 64'(lat), 64'd1);
    check_val("rej_a0_err", {63'b0, e}, 64'd1);
    check_val("rej_a0_inv", {32'b0, inv}, 64'd0);
    do_op(4, 33'd19, 32'd16, 1'b0, lat, e, inv);
    check_val("rej_wide_lat", 64'(lat), 64'd1);
    check_val("rej_wide_err", {63'b0, e}, 64'd1);
    check_val("rej_wide_inv", {32'b0, inv}, 64'd0);
    do_op(1, 33'd3, 32'd1, 1'b0, lat, e, inv);
    check_val("rej_m1_lat", 64'(lat), 64'd1);
    check_val("rej_m1_err", {63'b0, e}, 64'd1);
    do_op(40, 33'd19, 32'd3, 1'b0, lat, e, inv);
    check_val("rej_mbig_err", {63'b0, e}, 64'd1);
    check_val("rej_mbig_lat", 64'(lat), 64'd1);
    do_op(4, 33'd18, 32'd3, 1'b0, lat, e, inv);
    check_val("rej_feven_err", {63'b0, e}, 64'd1);
    check_val("rej_feven_lat", 64'(lat), 64'd1);

    // Reducible f = (x+1)^4 with a = x+1 shares a factor
    do_op(4, 33'd17, 32'd3, 1'b0, lat, e, inv);
    check_val("red_err", {63'b0, e}, 64'd1);
    check_val("red_inv", {32'b0, inv}, 64'd0);
    check_val("red_lat", 64'(lat <= 18), 64'd1);

    // start held high through RUN is ignored
    do_op(8, 33'd285, 32'h53, 1'b1, lat, e, inv);
    exp_inv = ref_inv(64'h53, 64'd285, 8);
    check_val("hold_inv", {32'b0, inv}, exp_inv);
    check_val("hold_err", {63'b0, e}, 64'd0);

    // Reset during RUN aborts without a done pulse
    polyn_grade = 6'd16; polyn_red_in = 33'd69643; a = 32'hBEEF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check_val("mid_busy", {63'b0, busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("mid_rst_busy", {63'b0, busy}, 64'd0);
    check_val("mid_rst_done", {63'b0, done}, 64'd0);
    check_val("mid_rst_err",  {63'b0, err},  64'd0);
    check_val("mid_rst_inv",  {32'b0, inv_out}, 64'd0);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      saw_done = saw_done | done;
    end
    check_val("mid_no_done", {63'b0, saw_done}, 64'd0);
    do_op(16, 33'd69643, 32'hBEEF, 1'b0, lat, e, inv);
    exp_inv = ref_inv(64'hBEEF, 64'd69643, 16);
    check_val("after_rst_inv", {32'b0, inv}, exp_inv);
    check_val("after_rst_err", {63'b0, e}, 64'd0);

    // Random sweep over every tabulated degree
    for (int k = 0; k < 1000; k++) begin
      m  = 2 + (k % 15);
      f  = (DW+1)'(poly_tab[m-2]);
      av = DW'($urandom_range((1 << m) - 1, 1));
      do_op(m, f, av, 1'b0, lat, e, inv);
      exp_inv = ref_inv({32'b0, av}, {31'b0, f}, m);
      check_val("sw_err", {63'b0, e}, 64'd0);
      check_val("sw_inv", {32'b0, inv}, exp_inv);
      check_val("sw_prod", clmul_red({32'b0, av}, {32'b0, inv}, {31'b0, f}, m), 64'd1);
      check_val("sw_lat", 64'(lat <= 4 * m + 2), 64'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gf_inv_seq.md
# gf_inv_seq

Sequential GF(2^m) multiplicative inverter for the carry-less arithmetic datapath. It computes a^-1 mod f(x) with the binary extended Euclidean algorithm, one step per clock, for any field degree 2..DATA_WIDTH selected at run time. It is the inverse-direction companion of the carry-less multiply/reduce block: its result, multiplied and reduced by that block under the same `polyn_grade`/`polyn_red_in`, must return 1.

## Interface
- `DATA_WIDTH`, 32: maximum field degree m; operand and result width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `polyn_grade`  in  $clog2(DATA_WIDTH)+1  field degree m (2..DATA_WIDTH).
- `polyn_red_in`  in  DATA_WIDTH+1  reduction polynomial f, bit m set, bit 0 set.
- `a`  in  DATA_WIDTH  operand; bits >= m must be zero.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`; high = no inverse or bad request.
- `inv_out`  out  DATA_WIDTH  inverse; held from `done` until next accepted `start`.

## Operation
- Registers: u, v (DATA_WIDTH+1 bits), g1, g2 (DATA_WIDTH bits), f, m latched at start.
- States: IDLE, RUN, DONE.
- IDLE + `start`: if a==0, any a bit >= m set, m<2, m>DATA_WIDTH, or f[0]==0 -> DONE with err=1, inv_out=0. Otherwise load u=a, v=f, g1=1, g2=0 -> RUN.
- RUN, each cycle, first matching rule:
  - u==1 -> inv_out=g1, err=0 -> DONE.
  - v==1 -> inv_out=g2, err=0 -> DONE.
  - u==0 or v==0 -> err=1, inv_out=0 -> DONE (gcd(a,f) != 1).
  - u[0]==0 -> u=u>>1; g1 = half(g1).
  - v[0]==0 -> v=v>>1; g2 = half(g2).
  - u>v (unsigned) -> u=u^v, g1=g1^g2; else v=v^u, g2=g2^g1.
- half(g) = g[0] ? (g^f)>>1 : g>>1, computed on DATA_WIDTH+1 bits; the result never exceeds m bits.
- DONE: `done`=1 for exactly one cycle -> IDLE.
- `start` in RUN or DONE is ignored; it is not queued.
- f is not checked for irreducibility. A reducible f gives either a correct inverse or err=1, never a hang.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `inv_out`=0; state IDLE. Registers u, v, g1, g2 cleared.
- `rst` mid-RUN: the operation is aborted and no `done` is issued. Outputs reach reset values at that edge.
- Latency from the `start` edge to the `done` high cycle:
  - Rejected request: 1 cycle.
  - a==1: 2 cycles.
  - General case: at most 4*m+2 cycles.
- `busy` is high in every RUN cycle and low in IDLE and DONE.
- A new `start` can be accepted in the cycle after `done`.
- `inv_out` and `err` are registered outputs; there is no combinational input-to-output path.

## Structure
- Package `gf_pkg`:
  - state enum (IDLE/RUN/DONE);
  - irreducible-polynomial constants per degree 2..16: 7, 11, 19, 37, 67, 137, 285, 529, 1033, 2053, 4179, 8219, 17475, 32771, 69643;
  - function `gf_width(DATA_WIDTH)` for the `polyn_grade` width.
- Sub-module `gf_half_step`: combinational conditional halve by x mod f, parameterized by DATA_WIDTH. Instantiated twice, once for g1 and once for g2.
- FSM, compare/XOR logic and output registers live in `gf_inv_seq`.

## Test plan
- m=4, f=19, a=2 -> done within 18 cycles, err=0, inv_out=9. m=4, f=19, a=1 -> done exactly 2 cycles after start, inv_out=1.
- m=8, f=285, a=2 -> inv_out=142. For random nonzero a: inv_out nonzero, and carry-less multiply + reduce of (a, inv_out) with m=8, f=285 gives 1.
- a=0, or m=4 with a=16 -> done 1 cycle after start, err=1, inv_out=0.
- m=4, f=17 (reducible), a=3 -> err=1 within 18 cycles; `busy` never exceeds the 4*m+2 bound.
- `start` pulsed during RUN -> ignored, original result returned. `rst` mid-RUN -> no `done`, all outputs 0; a new request completes correctly afterward.
- Sweep m=2..16 with table polynomials and 1000 random operands -> every result verified via the multiply/reduce check, and cycle count ≤ 4*m+2.
